edge_delay_sched: RTL and testbench

- Synchronous, cycle-accurate scheduler that reproduces a pin-to-pin path delay (a to y) inside clocked logic.
- Detects level changes on input a, queues each change with a due-time, and applies it to y after a programmable number of clock cycles.
- Supports transport mode (every edge propagates) and inertial mode (pulses shorter than the delay are swallowed).
- Sits between a stimulus or control source and the path it models; used wherever the team needs a configurable, synthesizable delay in place of simulation-only path delays.

---
 rtl/edge_delay_sched.sv | 136 +++++++++++++
 tb/tb_edge_delay_sched.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/edge_delay_sched.sv
// Clocked a-to-y path delay: level changes on a are queued with a due-time and
// replayed on y after a programmable number of cycles (transport or inertial).
module edge_delay_sched #(
    parameter int CNT_W         = 4,
    parameter int DEPTH         = 4,
    parameter int DEFAULT_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [CNT_W-1:0]           cfg_delay,
    input  logic                       cfg_mode,
    input  logic                       a,
    output logic                       y,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TS_W  = CNT_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    typedef logic [TS_W-1:0]  ts_t;
    typedef logic [CNT_W-1:0] dly_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam ts_t  TS_ONE   = ts_t'(1);
    localparam dly_t DLY_ONE  = dly_t'(1);
    localparam dly_t DLY_RST  = dly_t'(DEFAULT_DELAY);

    // Queue storage; entries only become visible through count_reg, so no reset.
    logic level_mem [DEPTH];
    ts_t  due_mem   [DEPTH];

    ptr_t head_ptr_reg, head_ptr_next;
    ptr_t tail_ptr_reg, tail_ptr_next;
    cnt_t count_reg, count_next;
    ts_t  ts_reg;
    dly_t delay_reg;
    logic mode_reg;
    logic a_ref_reg;
    logic y_reg;
    logic overflow_reg;

    logic edge_det, empty, full, pop, tail_popped;
    logic push, cancel, drop, cfg_accept;
    ts_t  due_new;

    always_comb begin
        edge_det    = (a != a_ref_reg);
        empty       = (count_reg == '0);
        full        = (count_reg == CNT_FULL);
        pop         = !empty && (due_mem[head_ptr_reg] == ts_reg);
        tail_popped = pop && (count_reg == CNT_ONE);
        due_new     = ts_reg + {1'b0, delay_reg};
        cfg_accept  = cfg_we && empty && !edge_det;

        push   = 1'b0;
        cancel = 1'b0;
        drop   = 1'b0;
        if (edge_det) begin
            // Inertial: a new edge while the previous one is still in flight
            // means the pulse was too short, so both edges vanish.
            if (mode_reg && !empty && !tail_popped) begin
                cancel = 1'b1;
            end else if (!full || pop) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        count_next    = count_reg;
        head_ptr_next = head_ptr_reg;
        tail_ptr_next = tail_ptr_reg;
        if (push) begin
            count_next    = count_next + CNT_ONE;
            tail_ptr_next = tail_ptr_next + PTR_ONE;
        end
        if (pop) begin
            count_next    = count_next - CNT_ONE;
            head_ptr_next = head_ptr_next + PTR_ONE;
        end
        if (cancel) begin
            count_next    = count_next - CNT_ONE;
            tail_ptr_next = tail_ptr_next - PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            level_mem[tail_ptr_reg] <= a;
            due_mem[tail_ptr_reg]   <= due_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
            ts_reg       <= '0;
            delay_reg    <= DLY_RST;
            mode_reg     <= 1'b0;
            a_ref_reg    <= 1'b0;
            y_reg        <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            head_ptr_reg <= head_ptr_next;
            tail_ptr_reg <= tail_ptr_next;
            count_reg    <= count_next;
            ts_reg       <= ts_reg + TS_ONE;
            a_ref_reg    <= a;
            if (pop) begin
                y_reg <= level_mem[head_ptr_reg];
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (cfg_accept) begin
                overflow_reg <= 1'b0;
            end
            if (cfg_accept) begin
                delay_reg <= (cfg_delay == '0) ? DLY_ONE : cfg_delay;
                mode_reg  <= cfg_mode;
            end
        end
    end

    assign y        = y_reg;
    assign busy     = (count_reg != '0);
    assign pending  = count_reg;
    assign overflow = overflow_reg;
endmodule

// File: tb/tb_edge_delay_sched.sv
// Directed bench for edge_delay_sched: latency, overflow, inertial rejection,
// timestamp wrap, configuration gating and mid-run reset.
module tb_edge_delay_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_delay;
    logic       cfg_mode;
    logic       a;
    logic       y;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int total_cnt = 0;
    int pass_cnt  = 0;

    edge_delay_sched #(.CNT_W(4), .DEPTH(4), .DEFAULT_DELAY(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_delay(cfg_delay),
        .cfg_mode (cfg_mode),
        .a        (a),
        .y        (y),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            pass_cnt++;
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // One clock; inputs are applied and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [3:0] d, input logic m);
        cfg_we = 1'b1; cfg_delay = d; cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_delay = 4'd0; cfg_mode = 1'b0; a = 1'b0;

        // 1: reset values, default delay 2
        do_reset();
        check("rst_y", y, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        repeat (3) tick();
        a = 1'b1; tick();
        check("t1_rise_pending", pending, 1);
        check("t1_rise_busy", busy, 1);
        check("t1_rise_y0", y, 0);
        tick(); check("t1_rise_y1", y, 0);
        tick(); check("t1_rise_y2", y, 1);
        check("t1_rise_drained", pending, 0);
        repeat (2) tick();
        a = 1'b0; tick();
        check("t1_fall_y0", y, 1);
        tick(); check("t1_fall_y1", y, 1);
        tick(); check("t1_fall_y2", y, 0);
        check("t1_overflow", overflow, 0);

        // 2: transport pulse train, delay 8, queue overflow
        configure(4'd8, 1'b0);
        for (int k = 0; k < 6; k++) begin
            a = ~a; tick();
            check($sformatf("t2_pending_%0d", k), pending, (k < 4) ? k + 1 : 4);
            check($sformatf("t2_overflow_%0d", k), overflow, (k >= 4) ? 1 : 0);
            check($sformatf("t2_y_%0d", k), y, 0);
        end
        tick(); check("t2_wait_y0", y, 0);
        tick(); check("t2_wait_y1", y, 0);
        tick(); check("t2_replay0", y, 1); check("t2_replay0_pend", pending, 3);
        tick(); check("t2_replay1", y, 0); check("t2_replay1_pend", pending, 2);
        tick(); check("t2_replay2", y, 1); check("t2_replay2_pend", pending, 1);
        tick(); check("t2_replay3", y, 0); check("t2_drained_busy", busy, 0);
        check("t2_overflow_sticky", overflow, 1);

        // 5: configuration rules
        configure(4'd0, 1'b0);
        check("t5_overflow_clr", overflow, 0);
        a = 1'b1; tick();
        check("t5_d1_y0", y, 0); check("t5_d1_pend", pending, 1);
        tick(); check("t5_d1_y1", y, 1);
        configure(4'd3, 1'b0);
        a = 1'b0; tick();
        check("t5_busy", busy, 1);
        configure(4'd1, 1'b0);
        check("t5_ign_y1", y, 1);
        tick(); check("t5_ign_y2", y, 1);
        tick(); check("t5_ign_y3", y, 0);
        a = 1'b1; tick();
        tick(); check("t5_old_delay_y1", y, 0);
        tick(); check("t5_old_delay_y2", y, 0);
        tick(); check("t5_old_delay_y3", y, 1);

        // 3: inertial rejection, delay 4
        a = 1'b0; tick(); repeat (3) tick();
        check("t3_pre_y", y, 0);
        configure(4'd4, 1'b1);
        a = 1'b1; tick(); check("t3_short_pend", pending, 1);
        tick();
        a = 1'b0; tick();
        check("t3_cancel_pend", pending, 0);
        check("t3_cancel_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); check($sformatf("t3_swallow_y_%0d", k), y, 0);
        end
        a = 1'b1; tick(); check("t3_long_pend", pending, 1);
        for (int k = 1; k <= 5; k++) begin
            tick(); check($sformatf("t3_long_rise_%0d", k), y, (k >= 4) ? 1 : 0);
        end
        a = 1'b0; tick(); check("t3_fall_pend", pending, 1);
        for (int k = 1; k <= 4; k++) begin
            tick(); check($sformatf("t3_long_fall_%0d", k), y, (k >= 4) ? 0 : 1);
        end

        // 4: timestamp wrap with delay 15; edges at ts 25, 27, 30
        do_reset();
        configure(4'd15, 1'b0);
        repeat (24) tick();
        for (int c = 0; c <= 22; c++) begin
            a = (c < 2) ? 1'b1 : (c < 5) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("t4_wrap_y_c%0d", c), y,
                  (c >= 20) ? 1 : (c >= 17) ? 0 : (c >= 15) ? 1 : 0);
        end

        // 6: reset mid-operation with three edges queued
        a = 1'b0; tick();
        a = 1'b1; tick();
        a = 1'b0; tick();
        check("t6_pre_pend", pending, 3);
        check("t6_pre_y", y, 1);
        do_reset();
        check("t6_rst_y", y, 0);
        check("t6_rst_pend", pending, 0);
        check("t6_rst_busy", busy, 0);
        for (int k = 0; k < 18; k++) begin
            tick();
            check($sformatf("t6_quiet_y_%0d", k), y, 0);
        end
        a = 1'b1; tick();
        tick(); check("t6_delay2_y1", y, 0);
        tick(); check("t6_delay2_y2", y, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
